// File: rtl/axi_line_fill_ctrl_if.sv
// rtl/axi_line_fill_ctrl_if.sv - AXI4 master bus bundle for the line fill controller
//
// Purpose: groups the five AXI4 channels used by axi_line_fill_ctrl for a
// single-burst victim writeback followed by a single-burst line refill.
// Modports:
//   master - controller side: drives AW/W/AR payload and VALIDs, BREADY, RREADY
//   slave  - memory side: drives AWREADY, WREADY, ARREADY, B and R channels
interface axi_line_fill_ctrl_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_ID_WIDTH-1:0]     awid;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;

  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wlast;
  logic                        wready;

  logic                        bvalid;
  logic [1:0]                  bresp;
  logic                        bready;

  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_ID_WIDTH-1:0]     arid;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;

  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic                        rvalid;
  logic                        rlast;
  logic [1:0]                  rresp;
  logic                        rready;

  modport master (
    output awaddr, awvalid, awid, awlen, awsize, awburst,
    output wdata, wstrb, wvalid, wlast,
    output bready,
    output araddr, arvalid, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, arready,
    input  rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    input  wdata, wstrb, wvalid, wlast,
    input  bready,
    input  araddr, arvalid, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, arready,
    output rdata, rvalid, rlast, rresp
  );
endinterface

// File: rtl/axi_line_fill_ctrl.sv
// rtl/axi_line_fill_ctrl.sv - cache line writeback/refill controller on AXI4
//
// Purpose: on a cache miss, optionally writes the dirty victim line back as one
// INCR burst, then refills the missing line as one INCR burst, forwarding each
// read beat to the cache and pulsing done (with err) at the end.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   miss_req/miss_ready         request handshake (accepted only while idle)
//   miss_addr, victim_addr      refill / writeback byte addresses (line-aligned here)
//   miss_dirty                  victim needs writeback before refill
//   wb_beat/wb_data             victim beat index out, beat data in (combinational)
//   fill_valid/fill_beat/fill_data  refill beat strobe, index, data
//   done, err                   end-of-operation pulse and accumulated error
//   m_axi                       AXI4 master channels
module axi_line_fill_ctrl #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int LINE_BEATS     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_req,
  output logic                      miss_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] miss_addr,
  input  logic                      miss_dirty,
  input  logic [AXI_ADDR_WIDTH-1:0] victim_addr,
  output logic [3:0]                wb_beat,
  input  logic [AXI_DATA_WIDTH-1:0] wb_data,
  output logic                      fill_valid,
  output logic [3:0]                fill_beat,
  output logic [AXI_DATA_WIDTH-1:0] fill_data,
  output logic                      done,
  output logic                      err,
  axi_line_fill_ctrl_if.master      m_axi
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB_AW = 3'd1;
  localparam logic [2:0] S_WB_W  = 3'd2;
  localparam logic [2:0] S_WB_B  = 3'd3;
  localparam logic [2:0] S_RF_AR = 3'd4;
  localparam logic [2:0] S_RF_R  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // One line = LINE_BEATS beats of 8 bytes; the offset bits inside a line are dropped.
  localparam int                        OFF_BITS  = $clog2(LINE_BEATS * 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFF_BITS;
  localparam logic [3:0]                LAST_BEAT = 4'(LINE_BEATS - 1);
  localparam logic [7:0]                AX_LEN    = 8'(LINE_BEATS - 1);

  logic [2:0]                state;
  logic [3:0]                beat_cnt;
  logic [AXI_ADDR_WIDTH-1:0] wb_addr_q;
  logic [AXI_ADDR_WIDTH-1:0] rf_addr_q;
  logic                      err_q;
  logic                      last_beat;
  logic                      in_wb_w;
  logic                      in_rf_r;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign in_wb_w   = (state == S_WB_W);
  assign in_rf_r   = (state == S_RF_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= 4'd0;
      wb_addr_q <= '0;
      rf_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_req) begin
            wb_addr_q <= victim_addr & LINE_MASK;
            rf_addr_q <= miss_addr & LINE_MASK;
            err_q     <= 1'b0;
            beat_cnt  <= 4'd0;
            state     <= miss_dirty ? S_WB_AW : S_RF_AR;
          end
        end
        S_WB_AW: begin
          if (m_axi.awready) state <= S_WB_W;
        end
        S_WB_W: begin
          if (m_axi.wready) begin
            if (last_beat) begin
              beat_cnt <= 4'd0;
              state    <= S_WB_B;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        S_WB_B: begin
          if (m_axi.bvalid) begin
            err_q <= err_q | (m_axi.bresp != 2'b00);
            state <= S_RF_AR;
          end
        end
        S_RF_AR: begin
          if (m_axi.arready) state <= S_RF_R;
        end
        S_RF_R: begin
          if (m_axi.rvalid) begin
            // The burst length is owned by the beat counter; RLAST only has
            // to agree with it, and any disagreement is reported, not obeyed.
            err_q <= err_q | (m_axi.rresp != 2'b00) | (m_axi.rlast != last_beat);
            if (last_beat) begin
              beat_cnt <= 4'd0;
              state    <= S_DONE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Cache side
  assign miss_ready = (state == S_IDLE);
  assign wb_beat    = beat_cnt;
  assign fill_valid = in_rf_r & m_axi.rvalid;
  assign fill_beat  = beat_cnt;
  assign fill_data  = m_axi.rdata;
  assign done       = (state == S_DONE);
  assign err        = err_q;

  // Write address / data / response
  assign m_axi.awvalid = (state == S_WB_AW);
  assign m_axi.awaddr  = wb_addr_q;
  assign m_axi.awid    = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.awlen   = AX_LEN;
  assign m_axi.awsize  = 3'd3;
  assign m_axi.awburst = 2'b01;
  assign m_axi.wvalid  = in_wb_w;
  assign m_axi.wdata   = wb_data;
  assign m_axi.wstrb   = {(AXI_DATA_WIDTH/8){1'b1}};
  assign m_axi.wlast   = in_wb_w & last_beat;
  assign m_axi.bready  = (state == S_WB_B);

  // Read address / data
  assign m_axi.arvalid = (state == S_RF_AR);
  assign m_axi.araddr  = rf_addr_q;
  assign m_axi.arid    = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.arlen   = AX_LEN;
  assign m_axi.arsize  = 3'd3;
  assign m_axi.arburst = 2'b01;
  assign m_axi.rready  = in_rf_r;
endmodule

// File: tb/tb_axi_line_fill_ctrl.sv
// tb/tb_axi_line_fill_ctrl.sv - self-checking bench for axi_line_fill_ctrl
module tb_axi_line_fill_ctrl;
  localparam int LB = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_req, miss_dirty, miss_ready;
  logic [AW-1:0] miss_addr, victim_addr;
  logic [3:0]    wb_beat, fill_beat;
  logic [DW-1:0] wb_data, fill_data;
  logic          fill_valid, done, err;

  axi_line_fill_ctrl_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) m ();

  axi_line_fill_ctrl #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .LINE_BEATS(LB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .victim_addr(victim_addr),
    .wb_beat(wb_beat), .wb_data(wb_data),
    .fill_valid(fill_valid), .fill_beat(fill_beat), .fill_data(fill_data),
    .done(done), .err(err), .m_axi(m)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Cache victim line and memory refill line
  logic [DW-1:0] vmem [16];
  logic [DW-1:0] rmem [16];
  assign wb_data = vmem[wb_beat];

  // Slave behaviour knobs for the current operation
  logic [1:0]  op_bresp;
  logic [1:0]  op_rresp [16];
  logic [15:0] op_rlast;
  int          stall_pct, ax_delay;
  bit          w_toggle;

  // Observations from the last operation
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, fill_cnt, proto_err, meta_bad, w_stall_cnt;
  int          lat, b_cyc, ar_cyc;
  bit          timeout, aborted, start_ready, post_ready, post_done, err_seen;
  bit          abort_wvalid, abort_ready;
  logic [3:0]  abort_wbeat;
  logic [AW-1:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  awlen_seen, arlen_seen;
  logic [2:0]  arsize_seen;
  logic [1:0]  arburst_seen;
  logic [DW-1:0] w_data_seen [16];
  logic [DW-1:0] fill_data_seen [16];
  logic        w_last_seen [16];
  logic [3:0]  w_beat_seen [16];
  logic [3:0]  fill_beat_seen [16];

  // Reference model: rules of the operation in plain arithmetic
  function automatic bit model_err(input bit dirty);
    bit e;
    e = dirty && (op_bresp != 2'b00);
    for (int i = 0; i < LB; i++) begin
      if (op_rresp[i] != 2'b00) e = 1'b1;
      if (op_rlast[i] != (i == LB - 1)) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a - (a % (LB * 8));
  endfunction

  function automatic int model_latency(input bit dirty);
    return dirty ? (1 + LB + 1 + 1 + LB + 1) : (1 + LB + 1);
  endfunction

  function automatic bit rnd_ready();
    return $urandom_range(99) >= stall_pct;
  endfunction

  task automatic drive_idle_slave();
    m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; m.bresp = 2'b00;
    m.arready = 1'b0; m.rvalid = 1'b0; m.rdata = '0; m.rlast = 1'b0; m.rresp = 2'b00;
  endtask

  task automatic setup_op();
    for (int i = 0; i < 16; i++) begin
      vmem[i] = {$urandom, $urandom};
      rmem[i] = {$urandom, $urandom};
      op_rresp[i] = 2'b00;
    end
    op_bresp = 2'b00; op_rlast = 16'(1) << (LB - 1);
    stall_pct = 0; ax_delay = 0; w_toggle = 1'b0;
  endtask

  // Issues one miss and plays the AXI slave until done (or abort/timeout).
  task automatic run_op(input bit dirty, input logic [AW-1:0] maddr,
                        input logic [AW-1:0] vaddr, input int abort_w);
    bit aw_stall, w_stall, ar_stall, b_pend, r_pend, wtog;
    logic [AW-1:0] aw_prev, ar_prev;
    logic [DW-1:0] wd_prev;
    logic [3:0] wb_prev;
    int aw_wait, ar_wait, r_idx, ri;
    aw_stall = 0; w_stall = 0; ar_stall = 0; b_pend = 0; r_pend = 0; wtog = 1;
    aw_prev = '0; ar_prev = '0; wd_prev = '0; wb_prev = '0;
    aw_wait = 0; ar_wait = 0; r_idx = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; fill_cnt = 0;
    proto_err = 0; meta_bad = 0; w_stall_cnt = 0;
    lat = -1; b_cyc = -1; ar_cyc = -1; timeout = 0; aborted = 0;
    err_seen = 0; post_ready = 0; post_done = 0;
    @(negedge clk);
    drive_idle_slave();
    start_ready = miss_ready;
    miss_req = 1'b1; miss_dirty = dirty; miss_addr = maddr; victim_addr = vaddr;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (!miss_ready && !done) begin
        miss_req = 1'($urandom_range(1)); miss_dirty = 1'($urandom_range(1));
        miss_addr = $urandom; victim_addr = $urandom;
      end else begin
        miss_req = 1'b0;
      end
      m.awready = (aw_wait >= ax_delay);
      m.wready  = w_toggle ? (m.wvalid && wtog) : rnd_ready();
      if (w_toggle && m.wvalid) wtog = !wtog;
      m.bvalid  = b_pend && rnd_ready();
      m.bresp   = op_bresp;
      m.arready = (ar_wait >= ax_delay);
      ri = (r_idx < 16) ? r_idx : 15;
      m.rvalid  = r_pend && rnd_ready();
      m.rdata   = rmem[ri]; m.rresp = op_rresp[ri]; m.rlast = op_rlast[ri];
      #1;
      if (abort_w >= 0 && m.wvalid && w_hs == abort_w) begin
        rst_n = 1'b0;
        #1;
        abort_wvalid = m.wvalid; abort_ready = miss_ready; abort_wbeat = wb_beat;
        aborted = 1;
        break;
      end
      if (aw_stall && (!m.awvalid || m.awaddr !== aw_prev)) proto_err++;
      if (w_stall && (!m.wvalid || m.wdata !== wd_prev || wb_beat !== wb_prev)) proto_err++;
      if (ar_stall && (!m.arvalid || m.araddr !== ar_prev)) proto_err++;
      aw_stall = m.awvalid && !m.awready; aw_prev = m.awaddr;
      w_stall = m.wvalid && !m.wready; wd_prev = m.wdata; wb_prev = wb_beat;
      ar_stall = m.arvalid && !m.arready; ar_prev = m.araddr;
      if (w_stall) w_stall_cnt++;
      if (m.awvalid) aw_wait++;
      if (m.arvalid) ar_wait++;
      if (m.awvalid && m.awready) begin
        aw_hs++; aw_addr_seen = m.awaddr; awlen_seen = m.awlen;
        if (m.awid !== '0 || m.awsize !== 3'd3 || m.awburst !== 2'b01) meta_bad++;
      end
      if (m.wvalid && m.wready) begin
        if (w_hs < 16) begin
          w_data_seen[w_hs] = m.wdata; w_last_seen[w_hs] = m.wlast; w_beat_seen[w_hs] = wb_beat;
        end
        if (m.wstrb !== 8'hFF) meta_bad++;
        w_hs++;
        if (w_hs == LB) b_pend = 1;
      end
      if (m.bvalid && m.bready) begin b_hs++; b_pend = 0; b_cyc = cyc; end
      if (m.arvalid && m.arready) begin
        ar_hs++; ar_cyc = cyc; ar_addr_seen = m.araddr; arlen_seen = m.arlen;
        arsize_seen = m.arsize; arburst_seen = m.arburst;
        if (m.arid !== '0) meta_bad++;
        r_pend = 1; r_idx = 0;
      end
      if (fill_valid) begin
        if (fill_cnt < 16) begin
          fill_data_seen[fill_cnt] = fill_data; fill_beat_seen[fill_cnt] = fill_beat;
        end
        fill_cnt++;
      end
      if (m.rvalid && m.rready) begin
        r_hs++; r_idx++;
        if (r_idx == LB) r_pend = 0;
      end
      if (done) begin err_seen = err; lat = cyc; break; end
    end
    if (lat < 0 && !aborted) timeout = 1;
    if (!aborted) begin
      @(negedge clk);
      drive_idle_slave();
      miss_req = 1'b0;
      #1;
      post_ready = miss_ready; post_done = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_req = 1'b0; miss_dirty = 1'b0; miss_addr = '0; victim_addr = '0;
    drive_idle_slave(); setup_op();
    #2;
    checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL reset_miss_ready got=%b want=1", miss_ready); end
    checks++; if ({m.awvalid, m.wvalid, m.wlast, m.bready, m.arvalid, m.rready} !== 6'b0) begin
      failures++; $display("FAIL reset_bus_ctrl got=%b want=000000", {m.awvalid, m.wvalid, m.wlast, m.bready, m.arvalid, m.rready}); end
    checks++; if ({fill_valid, done, err} !== 3'b0) begin failures++; $display("FAIL reset_cache_out got=%b want=000", {fill_valid, done, err}); end
    checks++; if (wb_beat !== 4'd0) begin failures++; $display("FAIL reset_counter got=%0d want=0", wb_beat); end
    checks++; if (m.awaddr !== '0 || m.araddr !== '0) begin failures++; $display("FAIL reset_addr got=%h/%h want=0", m.awaddr, m.araddr); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_miss();
    setup_op(); ax_delay = 2;
    run_op(1'b0, 32'h8000_0040, 32'h0000_0000, -1);
    checks++; if (timeout || !start_ready) begin failures++; $display("FAIL clean_progress got=timeout%0d/ready%0d want=0/1", timeout, start_ready); end
    checks++; if (aw_hs !== 0) begin failures++; $display("FAIL clean_aw_count got=%0d want=0", aw_hs); end
    checks++; if (ar_hs !== 1) begin failures++; $display("FAIL clean_ar_count got=%0d want=1", ar_hs); end
    checks++; if (ar_addr_seen !== 32'h8000_0040) begin failures++; $display("FAIL clean_araddr got=%h want=80000040", ar_addr_seen); end
    checks++; if ({arlen_seen, arsize_seen, arburst_seen} !== {8'd3, 3'd3, 2'd1}) begin
      failures++; $display("FAIL clean_ar_attr got=%0d/%0d/%0d want=3/3/1", arlen_seen, arsize_seen, arburst_seen); end
    checks++; if (fill_cnt !== LB) begin failures++; $display("FAIL clean_fill_count got=%0d want=%0d", fill_cnt, LB); end
    for (int i = 0; i < LB; i++) begin
      checks++; if (fill_data_seen[i] !== rmem[i] || fill_beat_seen[i] !== 4'(i)) begin
        failures++; $display("FAIL clean_fill_beat%0d got=%h@%0d want=%h@%0d", i, fill_data_seen[i], fill_beat_seen[i], rmem[i], i); end
    end
    checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL clean_err got=%b want=0", err_seen); end
    checks++; if (post_done !== 1'b0 || post_ready !== 1'b1) begin
      failures++; $display("FAIL clean_after_done got=done%b/ready%b want=0/1", post_done, post_ready); end
    checks++; if (proto_err !== 0 || meta_bad !== 0) begin failures++; $display("FAIL clean_protocol got=%0d/%0d want=0/0", proto_err, meta_bad); end
  endtask

  task automatic test_dirty_zero_wait();
    setup_op();
    run_op(1'b1, 32'h4000_1000, 32'h0000_0020, -1);
    checks++; if (aw_hs !== 1 || aw_addr_seen !== 32'h0000_0020 || awlen_seen !== 8'd3) begin
      failures++; $display("FAIL dirty_aw got=%0d/%h/%0d want=1/00000020/3", aw_hs, aw_addr_seen, awlen_seen); end
    checks++; if (w_hs !== LB) begin failures++; $display("FAIL dirty_w_count got=%0d want=%0d", w_hs, LB); end
    for (int i = 0; i < LB; i++) begin
      checks++; if (w_data_seen[i] !== vmem[i] || w_beat_seen[i] !== 4'(i) || w_last_seen[i] !== (i == LB - 1)) begin
        failures++; $display("FAIL dirty_w_beat%0d got=%h/%0d/%b want=%h/%0d/%b", i, w_data_seen[i], w_beat_seen[i], w_last_seen[i], vmem[i], i, (i == LB - 1)); end
    end
    checks++; if (b_hs !== 1 || ar_hs !== 1 || ar_cyc <= b_cyc) begin
      failures++; $display("FAIL dirty_b_then_ar got=b%0d@%0d ar%0d@%0d want=1 then 1", b_hs, b_cyc, ar_hs, ar_cyc); end
    checks++; if (ar_addr_seen !== 32'h4000_1000) begin failures++; $display("FAIL dirty_araddr got=%h want=40001000", ar_addr_seen); end
    checks++; if (lat !== model_latency(1'b1)) begin failures++; $display("FAIL dirty_latency got=%0d want=%0d", lat, model_latency(1'b1)); end
    checks++; if (err_seen !== 1'b0 || meta_bad !== 0) begin failures++; $display("FAIL dirty_err got=%b/%0d want=0/0", err_seen, meta_bad); end
  endtask

  task automatic test_wready_toggle();
    setup_op(); w_toggle = 1'b1;
    run_op(1'b1, $urandom, $urandom, -1);
    checks++; if (w_hs !== LB || w_stall_cnt !== 3) begin
      failures++; $display("FAIL toggle_w_hs got=%0d/stalls%0d want=%0d/3", w_hs, w_stall_cnt, LB); end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL toggle_hold got=%0d want=0", proto_err); end
    for (int i = 0; i < LB; i++) begin
      checks++; if (w_data_seen[i] !== vmem[i] || w_beat_seen[i] !== 4'(i)) begin
        failures++; $display("FAIL toggle_w_beat%0d got=%h/%0d want=%h/%0d", i, w_data_seen[i], w_beat_seen[i], vmem[i], i); end
    end
    checks++; if (timeout || err_seen !== 1'b0) begin failures++; $display("FAIL toggle_end got=timeout%0d/err%b want=0/0", timeout, err_seen); end
  endtask

  task automatic test_error_responses();
    setup_op(); op_bresp = 2'b10;
    run_op(1'b1, $urandom, $urandom, -1);
    checks++; if (err_seen !== 1'b1 || fill_cnt !== LB) begin
      failures++; $display("FAIL bresp_err got=err%b/fill%0d want=1/%0d", err_seen, fill_cnt, LB); end
    setup_op(); op_rresp[2] = 2'b11;
    run_op(1'b0, $urandom, $urandom, -1);
    checks++; if (err_seen !== 1'b1 || fill_cnt !== LB) begin
      failures++; $display("FAIL rresp_err got=err%b/fill%0d want=1/%0d", err_seen, fill_cnt, LB); end
    checks++; if (fill_data_seen[2] !== rmem[2]) begin failures++; $display("FAIL rresp_forward got=%h want=%h", fill_data_seen[2], rmem[2]); end
    setup_op();
    run_op(1'b0, $urandom, $urandom, -1);
    checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL err_clears got=%b want=0", err_seen); end
  endtask

  task automatic test_rlast_errors();
    logic [15:0] pats [3];
    pats[0] = 16'b0010; pats[1] = 16'b1010; pats[2] = 16'b0000;
    for (int p = 0; p < 3; p++) begin
      setup_op(); op_rlast = pats[p];
      run_op(1'($urandom_range(1)), $urandom, $urandom, -1);
      checks++; if (r_hs !== LB || fill_cnt !== LB || err_seen !== model_err(1'b0) || timeout) begin
        failures++; $display("FAIL rlast_pat%0d got=r%0d/fill%0d/err%b want=%0d/%0d/%b", p, r_hs, fill_cnt, err_seen, LB, LB, model_err(1'b0)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    setup_op();
    run_op(1'b1, $urandom, $urandom, 2);
    checks++; if (aborted !== 1'b1) begin failures++; $display("FAIL abort_reached got=%b want=1", aborted); end
    checks++; if (abort_wvalid !== 1'b0 || abort_ready !== 1'b1 || abort_wbeat !== 4'd0) begin
      failures++; $display("FAIL abort_outputs got=wvalid%b/ready%b/beat%0d want=0/1/0", abort_wvalid, abort_ready, abort_wbeat); end
    @(negedge clk);
    miss_req = 1'b0; drive_idle_slave();
    @(negedge clk);
    rst_n = 1'b1;
    setup_op();
    run_op(1'b0, 32'h1000_0088, $urandom, -1);
    checks++; if (timeout || aw_hs !== 0 || ar_hs !== 1 || ar_addr_seen !== 32'h1000_0080) begin
      failures++; $display("FAIL after_reset_op got=timeout%0d aw%0d ar%0d addr%h want=0/0/1/10000080", timeout, aw_hs, ar_hs, ar_addr_seen); end
    checks++; if (fill_cnt !== LB || err_seen !== 1'b0 || fill_data_seen[LB-1] !== rmem[LB-1]) begin
      failures++; $display("FAIL after_reset_fill got=%0d/err%b want=%0d/0", fill_cnt, err_seen, LB); end
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 20; n++) begin
      bit d, e_exp;
      logic [AW-1:0] ma, va;
      setup_op();
      stall_pct = $urandom_range(50); ax_delay = $urandom_range(3);
      d = 1'($urandom_range(1)); ma = $urandom; va = $urandom;
      if ($urandom_range(3) == 0) op_bresp = 2'($urandom_range(3, 1));
      if ($urandom_range(3) == 0) op_rresp[$urandom_range(LB - 1)] = 2'($urandom_range(3, 1));
      if ($urandom_range(3) == 0) op_rlast = 16'($urandom_range(15));
      e_exp = model_err(d);
      run_op(d, ma, va, -1);
      checks++; if (timeout || !start_ready) begin failures++; $display("FAIL rnd%0d_progress got=timeout%0d/ready%0d want=0/1", n, timeout, start_ready); end
      checks++; if (aw_hs !== int'(d) || w_hs !== (d ? LB : 0) || b_hs !== int'(d)) begin
        failures++; $display("FAIL rnd%0d_wb_count got=aw%0d w%0d b%0d want=%0d/%0d/%0d", n, aw_hs, w_hs, b_hs, d, d ? LB : 0, d); end
      if (d) begin
        checks++; if (aw_addr_seen !== line_of(va)) begin failures++; $display("FAIL rnd%0d_awaddr got=%h want=%h", n, aw_addr_seen, line_of(va)); end
        for (int i = 0; i < LB; i++) begin
          checks++; if (w_data_seen[i] !== vmem[i] || w_last_seen[i] !== (i == LB - 1)) begin
            failures++; $display("FAIL rnd%0d_w%0d got=%h/%b want=%h/%b", n, i, w_data_seen[i], w_last_seen[i], vmem[i], (i == LB - 1)); end
        end
      end
      checks++; if (ar_hs !== 1 || ar_addr_seen !== line_of(ma)) begin
        failures++; $display("FAIL rnd%0d_ar got=%0d/%h want=1/%h", n, ar_hs, ar_addr_seen, line_of(ma)); end
      checks++; if (fill_cnt !== LB) begin failures++; $display("FAIL rnd%0d_fill_count got=%0d want=%0d", n, fill_cnt, LB); end
      for (int i = 0; i < LB; i++) begin
        checks++; if (fill_data_seen[i] !== rmem[i] || fill_beat_seen[i] !== 4'(i)) begin
          failures++; $display("FAIL rnd%0d_fill%0d got=%h@%0d want=%h@%0d", n, i, fill_data_seen[i], fill_beat_seen[i], rmem[i], i); end
      end
      checks++; if (err_seen !== e_exp) begin failures++; $display("FAIL rnd%0d_err got=%b want=%b", n, err_seen, e_exp); end
      checks++; if (post_done !== 1'b0 || post_ready !== 1'b1) begin
        failures++; $display("FAIL rnd%0d_done_pulse got=done%b/ready%b want=0/1", n, post_done, post_ready); end
      checks++; if (proto_err !== 0 || meta_bad !== 0) begin failures++; $display("FAIL rnd%0d_protocol got=%0d/%0d want=0/0", n, proto_err, meta_bad); end
      if (stall_pct == 0 && ax_delay == 0) begin
        checks++; if (lat !== model_latency(d)) begin failures++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, model_latency(d)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_zero_wait();
    test_wready_toggle();
    test_error_responses();
    test_rlast_errors();
    test_reset_mid_burst();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
